spmmio_stream_master: RTL

// Bus initiator for the SPMMIO register bus: turns a byte-stream command channel (host UART/debug

---
 rtl/spmmio_pkg.sv | 26 ++
 rtl/spmmio_tx_ser.sv | 55 +++++
 rtl/spmmio_stream_master.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/spmmio_pkg.sv
// Shared SPMMIO stream-master definitions: header field positions, widths, FSM states, response bytes.
package spmmio_pkg;

  localparam int ADR_W = 4;
  localparam int SEL_W = 4;
  localparam int DAT_W = 32;

  // Header byte fields, bit 0 = MSB
  localparam int HDR_WE     = 0;
  localparam int HDR_RSV_LO = 1;
  localparam int HDR_RSV_HI = 3;
  localparam int HDR_ADR_LO = 4;
  localparam int HDR_ADR_HI = 7;

  localparam logic [0:7] ACK_BYTE_DEF = 8'hA5;
  localparam logic [0:7] ERR_BYTE_DEF = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_SEL,
    ST_GET_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/spmmio_tx_ser.sv
// Response serializer: loads a 32-bit word and emits 1 or 4 bytes MSB first on a valid/ready port.
// First byte valid one cycle after load; full rate under ready=1; byte held stable while stalled.
module spmmio_tx_ser
  import spmmio_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ld,
  input  logic [0:DAT_W-1] i_ld_dat,
  input  logic             i_ld_four,
  output logic [0:7]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_done
);

  logic [0:DAT_W-1] r_buf;
  logic             r_have;
  logic [1:0]       r_rem;
  logic [0:7]       r_tx_data;
  logic             r_tx_valid;
  logic             w_xfer;

  assign w_xfer     = r_tx_valid && i_tx_ready;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_done     = w_xfer && !r_have;

  // r_have: buffer still holds bytes not yet presented; r_rem: how many beyond the next one
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_buf      <= '0;
      r_have     <= 1'b0;
      r_rem      <= 2'd0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
    end else if (i_ld) begin
      r_buf  <= i_ld_dat;
      r_have <= 1'b1;
      r_rem  <= i_ld_four ? 2'd3 : 2'd0;
    end else if (r_have && (!r_tx_valid || i_tx_ready)) begin
      r_tx_data  <= r_buf[0:7];
      r_buf      <= {r_buf[8:DAT_W-1], 8'h00};
      r_tx_valid <= 1'b1;
      if (r_rem == 2'd0) begin
        r_have <= 1'b0;
      end else begin
        r_rem <= r_rem - 2'd1;
      end
    end else if (w_xfer) begin
      r_tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/spmmio_stream_master.sv
// Byte-stream to SPMMIO bus initiator: one cs cycle per frame, then a 1- or 4-byte response.
// Last frame byte at edge N -> cs in N..N+1 -> tx_valid after N+2; rx_ready low while a command is in flight.
module spmmio_stream_master
  import spmmio_pkg::*;
#(
  parameter logic [0:7] ACK_BYTE   = ACK_BYTE_DEF,
  parameter logic [0:7] ERR_BYTE   = ERR_BYTE_DEF,
  parameter int         RX_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:7]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [0:7]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [0:ADR_W-1] adr,
  output logic             cs,
  output logic [0:SEL_W-1] sel,
  output logic             we,
  output logic [0:DAT_W-1] d,
  input  logic [0:DAT_W-1] q
);

  localparam int TOW = (RX_TIMEOUT > 2) ? $clog2(RX_TIMEOUT) : 1;
  localparam logic [TOW-1:0] TO_LAST = TOW'(RX_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_rdy_en;
  logic [TOW-1:0]   r_to_cnt;
  logic [1:0]       r_bcnt;
  logic [0:ADR_W-1] r_f_adr;
  logic [0:SEL_W-1] r_f_sel;
  logic [0:23]      r_f_d;
  logic             r_cs;
  logic             r_we;
  logic [0:ADR_W-1] r_adr;
  logic [0:SEL_W-1] r_sel;
  logic [0:DAT_W-1] r_d;

  logic             w_rx_acc;
  logic             w_hdr_bad;
  logic             w_in_get;
  logic             w_to_hit;
  logic             w_ld;
  logic             w_ld_four;
  logic [0:DAT_W-1] w_ld_dat;
  logic             w_ser_done;

  assign w_in_get  = (r_state == ST_GET_SEL) || (r_state == ST_GET_DATA);
  assign rx_ready  = r_rdy_en && ((r_state == ST_IDLE) || w_in_get);
  assign w_rx_acc  = rx_valid && rx_ready;
  assign w_hdr_bad = |rx_data[HDR_RSV_LO:HDR_RSV_HI];
  assign w_to_hit  = (RX_TIMEOUT != 0) && w_in_get && !w_rx_acc && (r_to_cnt == TO_LAST);

  assign cs  = r_cs;
  assign we  = r_we;
  assign adr = r_adr;
  assign sel = r_sel;
  assign d   = r_d;

  always_comb begin
    w_state_nxt = r_state;
    w_ld        = 1'b0;
    w_ld_four   = 1'b0;
    w_ld_dat    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_rx_acc) begin
          if (w_hdr_bad) begin
            w_state_nxt = ST_RESP;
            w_ld        = 1'b1;
            w_ld_dat    = {ERR_BYTE, 24'h000000};
          end else if (rx_data[HDR_WE]) begin
            w_state_nxt = ST_GET_SEL;
          end else begin
            w_state_nxt = ST_BUS;
          end
        end
      end
      ST_GET_SEL: begin
        if (w_rx_acc)      w_state_nxt = ST_GET_DATA;
        else if (w_to_hit) w_state_nxt = ST_IDLE;
      end
      ST_GET_DATA: begin
        if (w_rx_acc && (r_bcnt == 2'd3)) w_state_nxt = ST_BUS;
        else if (w_to_hit)                w_state_nxt = ST_IDLE;
      end
      ST_BUS: begin
        // q is only valid while cs is high, so the read word is captured at the end of this cycle
        w_state_nxt = ST_RESP;
        w_ld        = 1'b1;
        w_ld_four   = !r_we;
        w_ld_dat    = r_we ? {ACK_BYTE, 24'h000000} : q;
      end
      ST_RESP: begin
        if (w_ser_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_rdy_en <= 1'b0;
      r_to_cnt <= '0;
      r_bcnt   <= 2'd0;
      r_f_adr  <= '0;
      r_f_sel  <= '0;
      r_f_d    <= '0;
      r_cs     <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= '0;
      r_sel    <= '0;
      r_d      <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rdy_en <= 1'b1;
      r_to_cnt <= (w_in_get && !w_rx_acc && !w_to_hit) ? r_to_cnt + TOW'(1) : '0;
      if ((r_state == ST_IDLE) && w_rx_acc) r_f_adr <= rx_data[HDR_ADR_LO:HDR_ADR_HI];
      if ((r_state == ST_GET_SEL) && w_rx_acc) begin
        r_f_sel <= rx_data[4:7];
        r_bcnt  <= 2'd0;
      end
      if ((r_state == ST_GET_DATA) && w_rx_acc) begin
        r_f_d  <= {r_f_d[8:23], rx_data};
        r_bcnt <= r_bcnt + 2'd1;
      end
      r_cs <= (w_state_nxt == ST_BUS);
      r_we <= (w_state_nxt == ST_BUS) && (r_state == ST_GET_DATA);
      if (w_state_nxt == ST_BUS) begin
        if (r_state == ST_GET_DATA) begin
          r_adr <= r_f_adr;
          r_sel <= r_f_sel;
          r_d   <= {r_f_d, rx_data};
        end else begin
          r_adr <= rx_data[HDR_ADR_LO:HDR_ADR_HI];
          r_sel <= '1;
          r_d   <= '0;
        end
      end
    end
  end

  spmmio_tx_ser u_tx_ser (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_ld       (w_ld),
    .i_ld_dat   (w_ld_dat),
    .i_ld_four  (w_ld_four),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_done     (w_ser_done)
  );

endmodule
